// File: rtl/branch_history_table.sv
// rtl/branch_history_table.sv - 2-bit saturating-counter branch history table with sweep clear
module branch_history_table #(
    parameter int BHT_IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] q_pc,
    output logic        q_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_pred_taken,
    input  logic        clear_req,
    output logic        busy,
    output logic        mis_valid,
    output logic [31:0] br_count,
    output logic [31:0] mis_count
);
    localparam int ENTRIES = 1 << BHT_IDX_W;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t               state;
    logic [1:0]           tbl [ENTRIES];
    logic [BHT_IDX_W-1:0] sweep_idx;
    logic [BHT_IDX_W-1:0] q_idx;
    logic [BHT_IDX_W-1:0] upd_idx;
    logic [BHT_IDX_W-1:0] pend_idx;
    logic                 pend_valid;
    logic                 pend_taken;
    logic [1:0]           pend_old;
    logic [1:0]           pend_new;
    logic                 accept;
    logic                 mispredict;
    logic                 unused_pc_bits;

    assign q_idx          = q_pc[BHT_IDX_W+1:2];
    assign upd_idx        = upd_pc[BHT_IDX_W+1:2];
    assign unused_pc_bits = ^{q_pc[31:BHT_IDX_W+2], q_pc[1:0], upd_pc[31:BHT_IDX_W+2], upd_pc[1:0]};

    assign accept     = upd_valid && !busy;
    assign mispredict = upd_taken != upd_pred_taken;

    always_comb begin
        pend_old = tbl[pend_idx];
        pend_new = pend_old;
        if (pend_taken) begin
            if (pend_old != 2'd3) pend_new = pend_old + 2'd1;
        end else begin
            if (pend_old != 2'd0) pend_new = pend_old - 2'd1;
        end
    end

    // A query that hits the not-yet-written pending entry sees its post-update value.
    always_comb begin
        q_taken = 1'b0;
        if (!busy) begin
            if (pend_valid && (q_idx == pend_idx)) q_taken = pend_new[1];
            else                                   q_taken = tbl[q_idx][1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) tbl[i] <= 2'd1;
            state      <= IDLE;
            busy       <= 1'b0;
            sweep_idx  <= '0;
            pend_valid <= 1'b0;
            pend_idx   <= '0;
            pend_taken <= 1'b0;
            mis_valid  <= 1'b0;
            br_count   <= '0;
            mis_count  <= '0;
        end else if (rdy) begin
            if (pend_valid) tbl[pend_idx] <= pend_new;

            pend_valid <= accept;
            if (accept) begin
                pend_idx   <= upd_idx;
                pend_taken <= upd_taken;
            end
            mis_valid <= accept && mispredict;

            if (accept && (br_count != 32'hFFFF_FFFF)) br_count <= br_count + 32'd1;
            if (accept && mispredict && (mis_count != 32'hFFFF_FFFF)) mis_count <= mis_count + 32'd1;

            // The sweep write comes after the pending write so it wins on a shared index.
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state     <= SWEEP;
                        busy      <= 1'b1;
                        sweep_idx <= '0;
                    end
                end
                SWEEP: begin
                    tbl[sweep_idx] <= 2'd1;
                    if (&sweep_idx) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        sweep_idx <= '0;
                    end else begin
                        sweep_idx <= sweep_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end else begin
            mis_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_branch_history_table.sv
// tb/tb_branch_history_table.sv - scoreboard bench for branch_history_table
module tb_branch_history_table;
    localparam int N = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b0;
    logic [31:0] q_pc = '0;
    logic        q_taken;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic        upd_pred_taken = 1'b0;
    logic        clear_req = 1'b0;
    logic        busy;
    logic        mis_valid;
    logic [31:0] br_count;
    logic [31:0] mis_count;

    always #5 clk = ~clk;

    branch_history_table #(.BHT_IDX_W(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .q_pc(q_pc), .q_taken(q_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_pred_taken(upd_pred_taken), .clear_req(clear_req), .busy(busy),
        .mis_valid(mis_valid), .br_count(br_count), .mis_count(mis_count)
    );

    typedef struct {
        logic        qt;
        logic        bsy;
        logic        mv;
        logic [31:0] br;
        logic [31:0] mc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model: counters change logically at the accepting edge.
    int          ctr[N];
    int          sweep_left = 0;
    bit          mvalid = 0;
    logic        m_mis = 1'b0;
    logic [31:0] m_br = '0;
    logic [31:0] m_mc = '0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic step(input bit r, input bit rd, input bit uv, input logic [31:0] up,
                        input bit ut, input bit pp, input bit cr, input logic [31:0] qp,
                        input bit fb);
        exp_t e;
        int   ui;
        @(posedge clk);
        #1;
        if (fb) begin
            force dut.br_count = 32'hFFFF_FFFF;
            #1;
            release dut.br_count;
            m_br = 32'hFFFF_FFFF;
        end
        rst = r; rdy = rd; upd_valid = uv; upd_pc = up; upd_taken = ut;
        upd_pred_taken = pp; clear_req = cr; q_pc = qp;
        if (mvalid) begin
            e.qt  = (sweep_left == 0) && (ctr[idx_of(qp)] >= 2);
            e.bsy = sweep_left > 0;
            e.mv  = m_mis;
            e.br  = m_br;
            e.mc  = m_mc;
            sb.push_back(e);
        end
        if (r) begin
            foreach (ctr[i]) ctr[i] = 1;
            sweep_left = 0; m_mis = 1'b0; m_br = '0; m_mc = '0; mvalid = 1;
        end else if (mvalid && rd) begin
            m_mis = 1'b0;
            if (uv && sweep_left == 0) begin
                ui = idx_of(up);
                ctr[ui] = ut ? ((ctr[ui] < 3) ? ctr[ui] + 1 : 3) : ((ctr[ui] > 0) ? ctr[ui] - 1 : 0);
                m_mis = (ut != pp);
                if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
                if (m_mis && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
            end
            if (sweep_left > 0) sweep_left--;
            else if (cr) begin
                sweep_left = N;
                foreach (ctr[i]) ctr[i] = 1;
            end
        end else begin
            m_mis = 1'b0;
        end
    endtask

    task automatic idle(input logic [31:0] qp);
        step(0, 1, 0, 32'h0, 0, 0, 0, qp, 0);
    endtask

    task automatic upd(input logic [31:0] pc, input bit t, input bit p, input logic [31:0] qp);
        step(0, 1, 1, pc, t, p, 0, qp, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("q_taken",   {31'b0, q_taken},   {31'b0, e.qt});
                check("busy",      {31'b0, busy},      {31'b0, e.bsy});
                check("mis_valid", {31'b0, mis_valid}, {31'b0, e.mv});
                check("br_count",  br_count,  e.br);
                check("mis_count", mis_count, e.mc);
            end
        end
    end

    initial begin : stimulus
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 32'h100, 1, 0, 1, 0, 0);
        for (int i = 0; i < N; i++) idle(32'(i * 4));

        upd(32'h100, 1, 0, 32'h100);
        upd(32'h100, 1, 0, 32'h100);
        repeat (2) idle(32'h100);

        for (int i = 0; i < 4; i++) upd(32'h100, 0, 1, 32'h100);
        repeat (2) idle(32'h100);

        upd(32'h200, 1, 1, 32'h0);
        idle(32'h200);
        idle(32'h204);

        step(0, 1, 1, 32'h0, 1, 0, 1, 32'h0, 0);
        for (int i = 0; i < N + 2; i++)
            step(0, 1, 1, $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom, 0);
        for (int i = 0; i <= N; i++) upd(32'(i * 4), 1, 1, 32'((i == 0 ? 0 : i - 1) * 4));

        repeat (5) step(0, 0, 1, 32'h300, 1, 0, 1, 32'h300, 0);
        idle(32'h300);
        upd(32'h300, 1, 0, 32'h300);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 32'h300, 0);
        idle(32'h300);

        step(0, 1, 0, 0, 0, 0, 1, 0, 0);
        repeat (10) idle($urandom);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) idle($urandom);

        step(0, 1, 0, 0, 0, 0, 0, 0, 1);
        upd(32'h40, 1, 0, 32'h40);
        repeat (2) idle(32'h40);

        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) != 0),
                 $urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                 ($urandom_range(0, 99) == 0), $urandom, 0);

        repeat (4) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
